// File: rtl/pwm_dds.sv
// Multi-waveform DDS tone generator: phase accumulator stepping once per 256-clock
// PWM period, sine/triangle/saw/square sample, volume scaling and an 8-bit PWM.
module pwm_dds #(
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [1:0]         wave_sel,
  input  logic [7:0]         volume,
  output logic               pwm,
  output logic               sync
);

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'b00,
    WAVE_TRI    = 2'b01,
    WAVE_SAW    = 2'b10,
    WAVE_SQUARE = 2'b11
  } wave_e;

  // First quadrant of a 7-bit sine: floor(128*sin(pi*i/128)), i = 0..63.
  function automatic logic [6:0] quarter_sine(input logic [5:0] idx);
    logic [6:0] q;
    case (idx)
      6'd0:  q = 7'd0;
      6'd1:  q = 7'd3;
      6'd2:  q = 7'd6;
      6'd3:  q = 7'd9;
      6'd4:  q = 7'd12;
      6'd5:  q = 7'd15;
      6'd6:  q = 7'd18;
      6'd7:  q = 7'd21;
      6'd8:  q = 7'd24;
      6'd9:  q = 7'd28;
      6'd10: q = 7'd31;
      6'd11: q = 7'd34;
      6'd12: q = 7'd37;
      6'd13: q = 7'd40;
      6'd14: q = 7'd43;
      6'd15: q = 7'd46;
      6'd16: q = 7'd48;
      6'd17: q = 7'd51;
      6'd18: q = 7'd54;
      6'd19: q = 7'd57;
      6'd20: q = 7'd60;
      6'd21: q = 7'd63;
      6'd22: q = 7'd65;
      6'd23: q = 7'd68;
      6'd24: q = 7'd71;
      6'd25: q = 7'd73;
      6'd26: q = 7'd76;
      6'd27: q = 7'd78;
      6'd28: q = 7'd81;
      6'd29: q = 7'd83;
      6'd30: q = 7'd85;
      6'd31: q = 7'd88;
      6'd32: q = 7'd90;
      6'd33: q = 7'd92;
      6'd34: q = 7'd94;
      6'd35: q = 7'd96;
      6'd36: q = 7'd98;
      6'd37: q = 7'd100;
      6'd38: q = 7'd102;
      6'd39: q = 7'd104;
      6'd40: q = 7'd106;
      6'd41: q = 7'd108;
      6'd42: q = 7'd109;
      6'd43: q = 7'd111;
      6'd44: q = 7'd112;
      6'd45: q = 7'd114;
      6'd46: q = 7'd115;
      6'd47: q = 7'd117;
      6'd48: q = 7'd118;
      6'd49: q = 7'd119;
      6'd50: q = 7'd120;
      6'd51: q = 7'd121;
      6'd52: q = 7'd122;
      6'd53: q = 7'd123;
      6'd54: q = 7'd124;
      6'd55: q = 7'd124;
      6'd56: q = 7'd125;
      6'd57: q = 7'd126;
      6'd58: q = 7'd126;
      6'd59: q = 7'd127;
      6'd60: q = 7'd127;
      6'd61: q = 7'd127;
      6'd62: q = 7'd127;
      6'd63: q = 7'd127;
      default: q = 7'd0;
    endcase
    return q;
  endfunction

  // Sine folded from the quarter table: mirror on p[6], invert around mid-scale on p[7].
  function automatic logic [7:0] sine_wave(input logic [7:0] p);
    logic [5:0] idx;
    logic [6:0] h;
    idx = p[6] ? (6'd63 - p[5:0]) : p[5:0];
    h   = quarter_sine(idx);
    return p[7] ? (8'd127 - {1'b0, h}) : (8'd128 + {1'b0, h});
  endfunction

  function automatic logic [7:0] tri_wave(input logic [7:0] p);
    logic [7:0] t;
    t = {p[6:0], 1'b0};
    return p[7] ? (8'd255 - t) : t;
  endfunction

  function automatic logic [7:0] square_wave(input logic [7:0] p);
    return p[7] ? 8'd0 : 8'd255;
  endfunction

  // Gain (volume+1)/256 applied around mid-scale; the floor shift keeps the result in 0..255.
  function automatic logic [7:0] scale_sample(input logic [7:0] wave, input logic [7:0] vol);
    logic signed [17:0] s;
    logic signed [17:0] g;
    logic signed [17:0] prod;
    s    = $signed({10'd0, wave}) - 18'sd128;
    g    = $signed({10'd0, vol}) + 18'sd1;
    prod = s * g;
    return 8'((prod >>> 8) + 18'sd128);
  endfunction

  logic [7:0]         cnt_r;
  logic [PHASE_W-1:0] phase_r;
  logic [7:0]         duty_r;
  logic               pwm_r;
  logic               sync_r;

  logic               boundary_s;
  logic [7:0]         sample_s;
  logic [7:0]         wave_s;
  logic [7:0]         duty_next_s;
  logic [PHASE_W:0]   sum_s;

  assign boundary_s  = (cnt_r == 8'd255);
  assign sample_s    = phase_r[PHASE_W-1 -: 8];
  assign sum_s       = {1'b0, phase_r} + {1'b0, phase_inc};
  assign duty_next_s = scale_sample(wave_s, volume);

  // Waveform selection for the current phase sample.
  always_comb begin
    wave_s = 8'd0;
    case (wave_sel)
      WAVE_SINE:   wave_s = sine_wave(sample_s);
      WAVE_TRI:    wave_s = tri_wave(sample_s);
      WAVE_SAW:    wave_s = sample_s;
      WAVE_SQUARE: wave_s = square_wave(sample_s);
      default:     wave_s = 8'd0;
    endcase
  end

  // Free-running PWM counter; runs whether or not the generator is enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

  // Period boundary: latch the next duty and, when running, advance the phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_r <= {PHASE_W{1'b0}};
      duty_r  <= 8'd0;
      sync_r  <= 1'b0;
    end else begin
      sync_r <= 1'b0;
      if (boundary_s) begin
        duty_r <= duty_next_s;
        if (enable) begin
          phase_r <= sum_s[PHASE_W-1:0];
          sync_r  <= sum_s[PHASE_W];
        end
      end
    end
  end

  // PWM comparator, one cycle behind the counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_r <= 1'b0;
    end else begin
      pwm_r <= enable & (cnt_r < duty_r);
    end
  end

  assign pwm  = pwm_r;
  assign sync = sync_r;

endmodule

// File: tb/tb_pwm_dds.sv
// Bench for pwm_dds: a period-level reference model predicts each 256-cycle window of
// pwm/sync, a separate monitor collects the DUT's windows and compares them.
module tb_pwm_dds;
  localparam int PHASE_W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] phase_inc = 16'd0;
  logic [1:0]  wave_sel = 2'd0;
  logic [7:0]  volume = 8'd0;
  logic        pwm;
  logic        sync;

  pwm_dds #(.PHASE_W(PHASE_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .phase_inc(phase_inc),
    .wave_sel(wave_sel), .volume(volume), .pwm(pwm), .sync(sync)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [255:0] pwm_pat;
    logic [255:0] sync_pat;
  } rec_t;
  rec_t exp_q[$];

  int           m_phase;
  int           m_duty;
  int           m_k;
  logic [255:0] m_pwm;
  logic [255:0] m_sync;

  function automatic int q_ref(int i);
    return int'($floor(128.0 * $sin(3.141592653589793 * i / 128.0)));
  endfunction

  function automatic int wave_ref(int p, int sel);
    case (sel)
      0: begin
        if (p < 64)       return 128 + q_ref(p);
        else if (p < 128) return 128 + q_ref(127 - p);
        else if (p < 192) return 127 - q_ref(p - 128);
        else              return 127 - q_ref(255 - p);
      end
      1: return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      2: return p;
      default: return (p < 128) ? 255 : 0;
    endcase
  endfunction

  function automatic int duty_ref(int w, int v);
    real x;
    x = real'((w - 128) * (v + 1)) / 256.0;
    return int'($floor(x)) + 128;
  endfunction

  // One clock of the reference model for the inputs currently driven.
  task automatic step();
    int   nd;
    int   sum;
    rec_t r;
    if (enable && m_k < m_duty) m_pwm[m_k] = 1'b1;
    if (m_k == 255) begin
      nd = duty_ref(wave_ref(m_phase / 256, int'(wave_sel)), int'(volume));
      if (enable) begin
        sum = m_phase + int'(phase_inc);
        m_sync[255] = (sum > 65535);
        m_phase = sum % 65536;
      end
      m_duty = nd;
      r.pwm_pat = m_pwm;
      r.sync_pat = m_sync;
      exp_q.push_back(r);
      m_pwm = '0;
      m_sync = '0;
      m_k = 0;
    end else begin
      m_k++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    m_phase = 0;
    m_duty = 0;
    m_k = 0;
    m_pwm = '0;
    m_sync = '0;
  endtask

  task automatic run_periods(int n);
    repeat (n * 256) step();
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  // Monitor: gathers each 256-sample window from the DUT and checks it against the queue.
  initial begin
    int           k;
    int           period;
    logic [255:0] op;
    logic [255:0] os;
    rec_t         r;
    k = 0; period = 0; op = '0; os = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        checks++;
        if (pwm !== 1'b0 || sync !== 1'b0) begin
          errors++;
          $display("FAIL reset_outputs pwm=%b sync=%b required 0 0", pwm, sync);
        end
        k = 0; op = '0; os = '0;
      end else begin
        op[k] = (pwm === 1'b1);
        os[k] = (sync === 1'b1);
        if (pwm !== 1'b0 && pwm !== 1'b1) op[k] = 1'bx;
        if (k == 255) begin
          checks += 2;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL window_without_expectation period=%0d", period);
          end else begin
            r = exp_q.pop_front();
            if (op !== r.pwm_pat) begin
              errors++;
              $display("FAIL pwm_window period=%0d got %0d high %h required %0d high %h",
                       period, $countones(op), op, $countones(r.pwm_pat), r.pwm_pat);
            end
            if (os !== r.sync_pat) begin
              errors++;
              $display("FAIL sync_window period=%0d got %h required %h", period, os, r.sync_pat);
            end
          end
          period++;
          k = 0; op = '0; os = '0;
        end else begin
          k++;
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    errors++;
    $display("FAIL watchdog cycle budget exhausted");
    summary();
    $finish;
  end

  initial begin
    @(negedge clk);
    // 1: sine at DC, full volume
    do_reset(4);
    enable = 1'b1; wave_sel = 2'd0; phase_inc = 16'd0; volume = 8'd255;
    run_periods(4);
    // 2: sine sweep
    do_reset(4);
    phase_inc = 16'd256;
    run_periods(8);
    // 3: sawtooth at p=0, two volumes
    do_reset(4);
    wave_sel = 2'd2; phase_inc = 16'd0; volume = 8'd127;
    run_periods(3);
    volume = 8'd0;
    run_periods(2);
    // 4: square toggling every period
    wave_sel = 2'd3; phase_inc = 16'h8000; volume = 8'd255;
    run_periods(5);
    // 5: triangle with enable dropped mid-period
    wave_sel = 2'd1; phase_inc = 16'd256;
    repeat (130) step();
    enable = 1'b0;
    repeat (300) step();
    enable = 1'b1;
    run_periods(3);
    // 6: reset at counter value 100 with a non-zero phase
    while (m_k != 100) step();
    do_reset(1);
    run_periods(3);
    // Randomised inputs, including mid-period changes and enable toggles
    for (int i = 0; i < 40 * 256; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        wave_sel = 2'($urandom_range(0, 3));
        volume = 8'($urandom_range(0, 255));
        phase_inc = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 65535))
                                                : 16'($urandom_range(0, 2048));
      end
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      step();
    end
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations got %0d required 0", exp_q.size());
    end
    summary();
    $finish;
  end

endmodule
